// File: rtl/memlcd_pkg.sv
// Shared defaults and sizing helpers for the memory-LCD pixel feeder.
package memlcd_pkg;

   localparam int VCOM_DIV_DEFAULT = 32'd1666666;
   localparam int HI_WM_DEFAULT    = 32'd56;
   localparam int LO_WM_DEFAULT    = 32'd8;

   // Level counter must hold 0..depth inclusive, hence one bit beyond the pointer.
   function automatic int level_w(input int depth_log2);
      return depth_log2 + 32'd1;
   endfunction

   function automatic int vcom_cnt_w(input int div);
      return (div > 32'd1) ? $clog2(div) : 32'd1;
   endfunction

endpackage

// File: rtl/memlcd_fifo.sv
// Byte buffer for the memory-LCD feeder: first-word-fall-through read, flush with optional seed write.
module memlcd_fifo
   import memlcd_pkg::*;
#(
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                              i_clk,
   input  logic                              i_reset,
   input  logic                              i_flush,
   input  logic                              i_wr,
   input  logic [7:0]                        i_wdata,
   input  logic                              i_rd,
   output logic [7:0]                        o_rdata,
   output logic [level_w(DEPTH_LOG2)-1:0]    o_level,
   output logic                              o_full,
   output logic                              o_empty,
   output logic                              o_drop
);

   localparam int                    LVL_W    = level_w(DEPTH_LOG2);
   localparam int                    DEPTH    = 2 ** DEPTH_LOG2;
   localparam logic [LVL_W-1:0]      LVL_FULL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0]      LVL_ONE  = LVL_W'(1);
   localparam logic [LVL_W-1:0]      LVL_ZERO = LVL_W'(0);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);

   logic [7:0]            mem_r [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
   logic [DEPTH_LOG2-1:0] wr_addr_s, wr_ptr_nxt_s, rd_ptr_nxt_s;
   logic [LVL_W-1:0]      level_r, level_nxt_s;
   logic                  full_s, push_s, pop_s;

   // Push/pop decision; a flush discards any pop and restarts the buffer at slot 0.
   always_comb begin
      full_s       = (level_r == LVL_FULL);
      push_s       = 1'b0;
      pop_s        = 1'b0;
      o_drop       = 1'b0;
      wr_addr_s    = wr_ptr_r;
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      level_nxt_s  = level_r;
      if (i_flush) begin
         push_s       = i_wr;
         wr_addr_s    = PTR_ZERO;
         rd_ptr_nxt_s = PTR_ZERO;
         wr_ptr_nxt_s = i_wr ? PTR_ONE : PTR_ZERO;
         level_nxt_s  = i_wr ? LVL_ONE : LVL_ZERO;
      end else begin
         pop_s  = i_rd & (level_r != LVL_ZERO);
         push_s = i_wr & (~full_s | pop_s);
         o_drop = i_wr & full_s & ~pop_s;
         if (push_s) wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
         else        wr_ptr_nxt_s = wr_ptr_r;
         if (pop_s)  rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
         else        rd_ptr_nxt_s = rd_ptr_r;
         case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
         endcase
      end
   end

   // Storage array, deliberately without reset.
   always_ff @(posedge i_clk) begin
      if (push_s) mem_r[wr_addr_s] <= i_wdata;
   end

   // Pointers, level and registered status flags.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         level_r  <= LVL_ZERO;
         o_full   <= 1'b0;
         o_empty  <= 1'b1;
      end else begin
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
         level_r  <= level_nxt_s;
         o_full   <= (level_nxt_s == LVL_FULL);
         o_empty  <= (level_nxt_s == LVL_ZERO);
      end
   end

   assign o_rdata = mem_r[rd_ptr_r];
   assign o_level = level_r;

endmodule

// File: rtl/memlcd_feeder.sv
// Memory-LCD feeder: byte buffer, pixel unpacking, CTS hysteresis and VCOM generation.
// Optional dropped-byte statistics are built when MEMLCD_FEEDER_STATS_EN is defined.
module memlcd_feeder
   import memlcd_pkg::*;
#(
   parameter int PIX_W      = 6,
   parameter int DEPTH_LOG2 = 6,
   parameter int HI_WM      = HI_WM_DEFAULT,
   parameter int LO_WM      = LO_WM_DEFAULT,
   parameter int VCOM_DIV   = VCOM_DIV_DEFAULT
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic [7:0]                     i_byte,
   input  logic                           i_byte_valid,
   input  logic                           i_frame_start,
   input  logic                           i_pack,
   output logic [PIX_W-1:0]               o_pix,
   output logic                           o_pix_valid,
   input  logic                           i_pix_ready,
   output logic                           o_cts,
   output logic [level_w(DEPTH_LOG2)-1:0] o_level,
   output logic                           o_full,
   output logic                           o_empty,
   output logic                           o_ovf,
   input  logic                           i_vcom_en,
   output logic                           o_vcom,
   output logic                           o_va,
   output logic                           o_vb,
   output logic [15:0]                    o_drop_cnt
);

   localparam int   LVL_W   = level_w(DEPTH_LOG2);
   localparam int   CNT_W   = vcom_cnt_w(VCOM_DIV);
   localparam logic PACK_OK = (PIX_W <= 4) ? 1'b1 : 1'b0;

   logic [7:0]       head_s;
   logic             drop_s, pop_s, xfer_s, pack_eff_s, phase_nxt_s;
   logic             phase_r, pack_r;
   logic [CNT_W-1:0] vcnt_r;
   logic             vphase_r;

   memlcd_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_flush (i_frame_start),
      .i_wr    (i_byte_valid),
      .i_wdata (i_byte),
      .i_rd    (pop_s),
      .o_rdata (head_s),
      .o_level (o_level),
      .o_full  (o_full),
      .o_empty (o_empty),
      .o_drop  (drop_s)
   );

   assign o_pix_valid = ~o_empty;

   // Unpack control: in packed mode the byte is popped only after its high-nibble pixel.
   always_comb begin
      xfer_s      = ~o_empty & i_pix_ready;
      pack_eff_s  = 1'b0;
      pop_s       = 1'b0;
      phase_nxt_s = phase_r;
      if (phase_r) pack_eff_s = pack_r;
      else         pack_eff_s = i_pack & PACK_OK;
      if (!xfer_s) begin
         phase_nxt_s = phase_r;
         pop_s       = 1'b0;
      end else if (pack_eff_s && !phase_r) begin
         phase_nxt_s = 1'b1;
         pop_s       = 1'b0;
      end else begin
         phase_nxt_s = 1'b0;
         pop_s       = 1'b1;
      end
      if (o_empty)      o_pix = {PIX_W{1'b0}};
      else if (phase_r) o_pix = PIX_W'(head_s >> 4);
      else              o_pix = PIX_W'(head_s);
   end

   // Unpack phase and the pack mode captured at the start of each byte.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         phase_r <= 1'b0;
         pack_r  <= 1'b0;
      end else if (i_frame_start) begin
         phase_r <= 1'b0;
         pack_r  <= 1'b0;
      end else begin
         phase_r <= phase_nxt_s;
         if (!phase_r) pack_r <= i_pack & PACK_OK;
      end
   end

   // CTS hysteresis on the registered level; holds between the watermarks.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)                            o_cts <= 1'b1;
      else if (o_level >= LVL_W'(HI_WM))      o_cts <= 1'b0;
      else if (o_level <= LVL_W'(LO_WM))      o_cts <= 1'b1;
      else                                    o_cts <= o_cts;
   end

   // Sticky overflow flag, cleared by a frame start.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)            o_ovf <= 1'b0;
      else if (i_frame_start) o_ovf <= 1'b0;
      else if (drop_s)        o_ovf <= 1'b1;
      else                    o_ovf <= o_ovf;
   end

`ifdef MEMLCD_FEEDER_STATS_EN
   logic [15:0] drop_cnt_r;

   // Saturating dropped-byte counter.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)                                  drop_cnt_r <= 16'h0000;
      else if (i_frame_start)                       drop_cnt_r <= 16'h0000;
      else if (drop_s && (drop_cnt_r != 16'hFFFF))  drop_cnt_r <= drop_cnt_r + 16'h0001;
      else                                          drop_cnt_r <= drop_cnt_r;
   end

   assign o_drop_cnt = drop_cnt_r;
`else
   assign o_drop_cnt = 16'h0000;
`endif

   // VCOM divider; outputs are registered from the phase being loaded so they track it exactly.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         vcnt_r   <= CNT_W'(0);
         vphase_r <= 1'b0;
         o_vcom   <= 1'b0;
         o_va     <= 1'b0;
         o_vb     <= 1'b0;
      end else if (!i_vcom_en) begin
         vcnt_r   <= CNT_W'(0);
         vphase_r <= 1'b0;
         o_vcom   <= 1'b0;
         o_va     <= 1'b0;
         o_vb     <= 1'b0;
      end else if (vcnt_r == CNT_W'(VCOM_DIV - 1)) begin
         vcnt_r   <= CNT_W'(0);
         vphase_r <= ~vphase_r;
         o_vcom   <= vphase_r;
         o_va     <= ~vphase_r;
         o_vb     <= vphase_r;
      end else begin
         vcnt_r   <= vcnt_r + CNT_W'(1);
         vphase_r <= vphase_r;
         o_vcom   <= ~vphase_r;
         o_va     <= vphase_r;
         o_vb     <= ~vphase_r;
      end
   end

endmodule
